nor_array_tester: RTL and testbench

//   Sequential self-test driver/checker for the 4-pair NOR gate array (pair k: two inputs -> one NOR output).

---
 rtl/nor_array_tester.sv | 107 ++++++++++
 tb/tb_nor_array_tester.sv | 128 ++++++++++++
 2 files changed

// File: rtl/nor_array_tester.sv
// nor_array_tester: sweeps every input vector into a PAIRS-wide NOR array, checks each output against ~(a|b), counts failing vectors and records the first one (clk/rst_n/start in; dut_in out, dut_out in; busy/done/pass/err_count/fail_valid/first_fail out)
module nor_array_tester #(
    parameter int PAIRS  = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [2*PAIRS-1:0]   dut_in,
    input  logic [PAIRS-1:0]     dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*PAIRS:0]     err_count,
    output logic                 fail_valid,
    output logic [2*PAIRS-1:0]   first_fail
);
    localparam int VW = 2 * PAIRS;
    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;
    state_t          state_q, state_d;
    logic [VW-1:0]   vec_q, vec_d, din_q, din_d, ff_q, ff_d;
    logic [VW:0]     err_q, err_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            fv_q, fv_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [PAIRS-1:0] exp_out;
    logic            mismatch;
    always_comb begin
        exp_out = '0;
        for (int k = 0; k < PAIRS; k++) exp_out[k] = ~(din_q[2*k] | din_q[2*k+1]);
    end
    // case inequality so an X/Z output from the array registers as a failure
    assign mismatch = (dut_out !== exp_out);
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        din_d   = din_q;
        ff_d    = ff_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        fv_d    = fv_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                err_d   = '0;
                fv_d    = 1'b0;
                ff_d    = '0;
                vec_d   = '0;
                state_d = DRIVE;
            end
            DRIVE: begin
                din_d   = vec_q;
                cnt_d   = 4'(SETTLE);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? CHECK : WAIT;
            end
            CHECK: begin
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (!fv_q) begin
                        ff_d = din_q;
                        fv_d = 1'b1;
                    end
                end
                vec_d   = (vec_q == '1) ? vec_q : vec_q + 1'b1;
                state_d = (vec_q == '1) ? DONE : DRIVE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == DRIVE) || (state_d == WAIT) || (state_d == CHECK);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == '0);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            din_q   <= '0;
            ff_q    <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
            fv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            din_q   <= din_d;
            ff_q    <= ff_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            fv_q    <= fv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end
    assign dut_in     = din_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign first_fail = ff_q;
endmodule

// File: tb/tb_nor_array_tester.sv
// tb_nor_array_tester: table-driven sweeps of nor_array_tester against an ideal or faulted NOR array model
module tb_nor_array_tester;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [7:0] dut_in, first_fail;
    logic [3:0] dut_out;
    logic       busy, done, pass, fail_valid;
    logic [8:0] err_count;
    int         fault = 0;
    int         n_tests = 0, n_fail = 0;
    typedef struct {
        int         fault;
        int         extra;
        int         abort_at;
        logic [8:0] err;
        logic [7:0] ff;
        logic       fv;
        logic       ps;
    } vec_t;
    typedef struct {
        logic [8:0] err;
        logic [7:0] ff;
        logic       fv;
        logic       ps;
    } exp_t;
    exp_t sb[$];
    nor_array_tester #(.PAIRS(4), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .first_fail(first_fail)
    );
    always #5 clk = ~clk;
    always_comb begin
        dut_out = '0;
        for (int k = 0; k < 4; k++) dut_out[k] = ~(dut_in[2*k] | dut_in[2*k+1]);
        if (fault == 1) dut_out[0] = 1'b0;
        if (fault == 2) dut_out[2] = 1'b1;
        if (fault == 3) dut_out[3] = dut_in[6] | dut_in[7];
    end
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err_count, 0);
        check({tag, "_fv"}, fail_valid, 0);
        check({tag, "_ff"}, first_fail, 0);
        check({tag, "_din"}, dut_in, 0);
    endtask
    task automatic run(input vec_t t);
        int   n;
        logic prev_busy;
        exp_t e;
        @(negedge clk);
        fault = t.fault;
        start = 1'b1;
        if (t.abort_at == 0) sb.push_back('{t.err, t.ff, t.fv, t.ps});
        @(posedge clk);
        #1 start = 1'b0;
        check("start_clr_err", err_count, 0);
        check("start_clr_fv", fail_valid, 0);
        check("start_clr_ff", first_fail, 0);
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("start_pass", pass, 0);
        n = 0;
        prev_busy = 1'b1;
        while (n < 2000 && !done) begin
            if (n == t.extra - 1) begin
                @(negedge clk);
                start = 1'b1;
            end
            prev_busy = busy;
            @(posedge clk);
            #1 start = 1'b0;
            n++;
            if (n == t.abort_at) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1 check_all_zero("abort");
                @(negedge clk);
                rst_n = 1'b1;
                repeat (3) @(negedge clk);
                check("abort_idle_busy", busy, 0);
                check("abort_idle_done", done, 0);
                return;
            end
        end
        check("done_edge", n, 768);
        check("busy_before_done", prev_busy, 1);
        check("busy_at_done", busy, 0);
        check("din_holds_last", dut_in, 8'hFF);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        check("err_count", err_count, e.err);
        check("fail_valid", fail_valid, e.fv);
        check("pass", pass, e.ps);
        if (e.fv) check("first_fail", first_fail, e.ff);
    endtask
    initial begin
        vec_t tbl[8];
        tbl[0] = '{0, 0,   0,   9'd0,   8'h00, 1'b0, 1'b1};
        tbl[1] = '{0, 100, 0,   9'd0,   8'h00, 1'b0, 1'b1};
        tbl[2] = '{1, 0,   0,   9'd64,  8'h00, 1'b1, 1'b0};
        tbl[3] = '{0, 0,   0,   9'd0,   8'h00, 1'b0, 1'b1};
        tbl[4] = '{2, 0,   0,   9'd192, 8'h10, 1'b1, 1'b0};
        tbl[5] = '{3, 0,   0,   9'd256, 8'h00, 1'b1, 1'b0};
        tbl[6] = '{0, 0,   300, 9'd0,   8'h00, 1'b0, 1'b0};
        tbl[7] = '{0, 0,   0,   9'd0,   8'h00, 1'b0, 1'b1};
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        for (int i = 0; i < 8; i++) run(tbl[i]);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
